// File: rtl/zone_pkg.sv
// Shared definitions for the zone brightness packer.
// Contents:
//   ZONE_W / ZONES_PER_WORD / WORD_W : per-zone and per-word widths
//   out_state_e                      : output pacing FSM states
//   fifo_entry_t                     : queued word plus first-of-frame tag
package zone_pkg;

  localparam int unsigned ZONE_W         = 16;
  localparam int unsigned ZONES_PER_WORD = 6;
  localparam int unsigned WORD_W         = ZONE_W * ZONES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FRAME,
    ST_SEND,
    ST_GAP
  } out_state_e;

  typedef struct packed {
    logic              first;
    logic [WORD_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/zone_word_fifo.sv
// Synchronous word FIFO; DEPTH must be a power of two (>= 2).
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   push_i/wdata_i : write strobe and data
//   pop_i          : remove head entry
//   head_o         : current head entry (valid while !empty_o)
//   full_o/empty_o : occupancy flags
// A push while full is accepted only when a pop happens in the same cycle.
module zone_word_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 97
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/zone_rgb_packer.sv
// Packs the per-zone 16-bit brightness stream into 96-bit words for the
// SPI7001 driver stage, with word/frame strobes and a paced output.
// Ports:
//   clock, rst        : sole clock, synchronous active-high reset
//   zone_valid/ready  : input handshake (ready = FIFO not full)
//   zone_sof          : marks the first zone of a frame
//   zone_data         : zone brightness
//   rgb_data          : packed word, held between strobes
//   rgb_f / frame_f   : one-cycle word and frame strobes
//   frame_err         : one-cycle framing-error pulse
// Optional macro LEVEL_CLAMP_EN: clamp each value to MAX_LEVEL before packing.
module zone_rgb_packer
  import zone_pkg::*;
#(
  parameter int unsigned    ZONES_PER_FRAME = 96,
  parameter int unsigned    WORD_GAP        = 64,
  parameter int unsigned    FIFO_DEPTH      = 4,
  parameter logic [15:0]    MAX_LEVEL       = 16'hFFFF
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              zone_valid,
  input  logic              zone_sof,
  input  logic [ZONE_W-1:0] zone_data,
  output logic              zone_ready,
  output logic [WORD_W-1:0] rgb_data,
  output logic              rgb_f,
  output logic              frame_f,
  output logic              frame_err
);

  localparam int unsigned ZCNT_W = $clog2(ZONES_PER_FRAME);
  localparam int unsigned GAP_W  = $clog2(WORD_GAP);
  localparam int unsigned SLOT_W = $clog2(ZONES_PER_WORD);
  localparam int unsigned PART_W = WORD_W - ZONE_W;

`ifdef LEVEL_CLAMP_EN
  localparam logic [ZONE_W-1:0] CEIL = MAX_LEVEL;
`else
  // All-ones ceiling: the compare never fires, values pass unmodified.
  localparam logic [ZONE_W-1:0] CEIL = MAX_LEVEL | '1;
`endif

  // ---------------- input packing ----------------
  logic [ZONE_W-1:0] level;
  logic              accept;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  logic [PART_W-1:0] word_q,     word_d;
  logic [SLOT_W-1:0] slot_q,     slot_d;
  logic [ZCNT_W-1:0] zcnt_q,     zcnt_d;
  logic              tag_q,      tag_d;
  logic              in_frame_q, in_frame_d;
  logic              reported_q, reported_d;
  logic              err_q,      err_d;

  assign level      = (zone_data > CEIL) ? CEIL : zone_data;
  assign zone_ready = !fifo_full;
  assign accept     = zone_valid && zone_ready;

  always_comb begin
    word_d           = word_q;
    slot_d           = slot_q;
    zcnt_d           = zcnt_q;
    tag_d            = tag_q;
    in_frame_d       = in_frame_q;
    reported_d       = reported_q;
    err_d            = 1'b0;
    fifo_push        = 1'b0;
    push_entry.first = tag_q;
    // Sixth value is merged combinationally so the word is queued on its accept edge.
    push_entry.data  = {level, word_q};
    if (accept) begin
      if (zone_sof) begin
        err_d                 = in_frame_q;
        word_d                = '0;
        word_d[ZONE_W-1:0]    = level;
        slot_d                = SLOT_W'(1);
        zcnt_d                = ZCNT_W'(1);
        tag_d                 = 1'b1;
        in_frame_d            = 1'b1;
      end else if (in_frame_q) begin
        if (slot_q == SLOT_W'(ZONES_PER_WORD - 1)) begin
          fifo_push = 1'b1;
          slot_d    = '0;
          tag_d     = 1'b0;
        end else begin
          for (int unsigned k = 0; k < ZONES_PER_WORD - 1; k++) begin
            if (slot_q == SLOT_W'(k)) begin
              word_d[k*ZONE_W +: ZONE_W] = level;
            end
          end
          slot_d = slot_q + SLOT_W'(1);
        end
        if (zcnt_q == ZCNT_W'(ZONES_PER_FRAME - 1)) begin
          in_frame_d = 1'b0;
          zcnt_d     = '0;
          reported_d = 1'b0;
        end else begin
          zcnt_d = zcnt_q + ZCNT_W'(1);
        end
      end else if (!reported_q) begin
        // reported_q comes out of reset set, so pre-first-SOF values drop silently.
        err_d      = 1'b1;
        reported_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      word_q     <= '0;
      slot_q     <= '0;
      zcnt_q     <= '0;
      tag_q      <= 1'b0;
      in_frame_q <= 1'b0;
      reported_q <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      word_q     <= word_d;
      slot_q     <= slot_d;
      zcnt_q     <= zcnt_d;
      tag_q      <= tag_d;
      in_frame_q <= in_frame_d;
      reported_q <= reported_d;
      err_q      <= err_d;
    end
  end

  assign frame_err = err_q;

  // ---------------- word FIFO ----------------
  zone_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_entry_t))
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .wdata_i (push_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // ---------------- output pacing FSM ----------------
  out_state_e        state_q;
  logic [GAP_W-1:0]  gap_q;
  logic [WORD_W-1:0] rgb_data_q;
  logic              rgb_f_q;
  logic              frame_f_q;

  // Strobes and data are loaded on entry to SEND so they are visible during SEND,
  // the same cycle the head is popped.
  assign fifo_pop = (state_q == ST_SEND);

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      rgb_data_q <= '0;
      rgb_f_q    <= 1'b0;
      frame_f_q  <= 1'b0;
    end else begin
      rgb_f_q   <= 1'b0;
      frame_f_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty && (gap_q == '0)) begin
            if (head.first) begin
              frame_f_q <= 1'b1;
              state_q   <= ST_FRAME;
            end else begin
              rgb_f_q    <= 1'b1;
              rgb_data_q <= head.data;
              state_q    <= ST_SEND;
            end
          end
        end
        ST_FRAME: begin
          rgb_f_q    <= 1'b1;
          rgb_data_q <= head.data;
          state_q    <= ST_SEND;
        end
        ST_SEND: begin
          gap_q   <= GAP_W'(WORD_GAP - 1);
          state_q <= ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_q <= ST_IDLE;
          end else begin
            gap_q <= gap_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign rgb_data = rgb_data_q;
  assign rgb_f    = rgb_f_q;
  assign frame_f  = frame_f_q;

endmodule

// File: tb/tb_zone_rgb_packer.sv
// Bench for zone_rgb_packer: frame-level reference model plus directed and
// random stimulus. Honours LEVEL_CLAMP_EN when defined.
module tb_zone_rgb_packer;

  localparam int unsigned ZPF   = 96;
  localparam int unsigned GAP   = 64;
  localparam int unsigned DEPTH = 4;
  localparam logic [15:0] MAXL  = 16'h0FFF;

  logic        clock;
  logic        rst;
  logic        zone_valid;
  logic        zone_sof;
  logic [15:0] zone_data;
  logic        zone_ready;
  logic [95:0] rgb_data;
  logic        rgb_f;
  logic        frame_f;
  logic        frame_err;

  zone_rgb_packer #(
    .ZONES_PER_FRAME (ZPF),
    .WORD_GAP        (GAP),
    .FIFO_DEPTH      (DEPTH),
    .MAX_LEVEL       (MAXL)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .zone_valid (zone_valid),
    .zone_sof   (zone_sof),
    .zone_data  (zone_data),
    .zone_ready (zone_ready),
    .rgb_data   (rgb_data),
    .rgb_f      (rgb_f),
    .frame_f    (frame_f),
    .frame_err  (frame_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned checks = 0;
  int unsigned errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [96:0] exp_q [$];
  logic [15:0] m_vals [$];
  logic        m_in_frame = 1'b0;
  logic        m_reported = 1'b1;
  logic        m_tag      = 1'b0;
  int          m_zcnt     = 0;
  logic        m_push;
  logic        m_acc;
  logic        exp_err    = 1'b0;
  int          occ        = 0;
  logic        prev_ff    = 1'b0;
  logic        rst_prev   = 1'b0;
  int          last_rgb   = -1;
  int          ncyc       = 0;
  int          n_rgb = 0, n_ff = 0, n_err = 0;
  int          acc_cnt = 0, acc6_n = -1, ff1_n = -1, rgb1_n = -1;
  logic [95:0] rgb1_data  = '0;
  logic        saw_stall  = 1'b0;

  function automatic logic [15:0] mclamp(input logic [15:0] d);
`ifdef LEVEL_CLAMP_EN
    return (d > MAXL) ? MAXL : d;
`else
    return d;
`endif
  endfunction

  task automatic model_reset();
    m_vals.delete();
    m_in_frame = 1'b0;
    m_reported = 1'b1;
    m_tag      = 1'b0;
    m_zcnt     = 0;
  endtask

  task automatic model_accept(input logic sof, input logic [15:0] d);
    logic [95:0] w;
    if (sof) begin
      if (m_in_frame) exp_err = 1'b1;
      m_vals.delete();
      m_tag      = 1'b1;
      m_in_frame = 1'b1;
      m_zcnt     = 0;
    end else if (!m_in_frame) begin
      if (!m_reported) begin
        exp_err    = 1'b1;
        m_reported = 1'b1;
      end
      return;
    end
    m_vals.push_back(mclamp(d));
    m_zcnt++;
    if (m_vals.size() == 6) begin
      for (int k = 0; k < 6; k++) w[16*k +: 16] = m_vals[k];
      exp_q.push_back({m_tag, w});
      m_push = 1'b1;
      m_vals.delete();
      m_tag = 1'b0;
    end
    if (m_zcnt == ZPF) begin
      m_in_frame = 1'b0;
      m_reported = 1'b0;
    end
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    ncyc++;
    if (rst_prev) begin
      chk("rst_rgb_data", rgb_data, 96'h0);
      chk("rst_rgb_f", rgb_f, 1'b0);
      chk("rst_frame_f", frame_f, 1'b0);
      chk("rst_frame_err", frame_err, 1'b0);
      chk("rst_zone_ready", zone_ready, 1'b1);
    end else begin
      chk("frame_err", frame_err, exp_err);
      chk("zone_ready", zone_ready, occ < DEPTH);
      if (!zone_ready) saw_stall = 1'b1;
      if (frame_err) n_err++;
      if (frame_f) begin
        n_ff++;
        if (ff1_n < 0) ff1_n = ncyc;
        chk("frame_f_has_word", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) chk("frame_f_word_tagged", exp_q[0][96], 1'b1);
      end
      if (prev_ff) chk("rgb_f_after_frame_f", rgb_f, 1'b1);
      if (rgb_f) begin
        n_rgb++;
        if (rgb1_n < 0) begin
          rgb1_n    = ncyc;
          rgb1_data = rgb_data;
        end
        chk("rgb_f_has_word", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          chk("rgb_data", rgb_data, exp_q[0][95:0]);
          chk("frame_f_before_tagged", prev_ff, exp_q[0][96]);
          void'(exp_q.pop_front());
        end
        if (last_rgb >= 0) chk("rgb_spacing", ncyc - last_rgb, (ncyc - last_rgb) >= GAP ? ncyc - last_rgb : GAP);
        last_rgb = ncyc;
      end
    end
    prev_ff = frame_f;
    m_push  = 1'b0;
    exp_err = 1'b0;
    if (rst) begin
      model_reset();
      exp_q.delete();
      occ      = 0;
      last_rgb = -1;
      rst_prev = 1'b1;
      prev_ff  = 1'b0;
    end else begin
      rst_prev = 1'b0;
      m_acc = zone_valid && zone_ready;
      if (m_acc) begin
        acc_cnt++;
        if (acc_cnt == 6) acc6_n = ncyc;
        model_accept(zone_sof, zone_data);
      end
      occ = occ + (m_push ? 1 : 0) - (rgb_f ? 1 : 0);
    end
  end

  // ---------------- stimulus helpers (called at posedge+1) ----------------
  task automatic push_val(input logic sof, input logic [15:0] d);
    int unsigned t = 0;
    zone_valid = 1'b1;
    zone_sof   = sof;
    zone_data  = d;
    forever begin
      @(negedge clock);
      if (zone_ready) begin
        @(posedge clock);
        #1;
        break;
      end
      @(posedge clock);
      #1;
      t++;
      if (t > 20000) begin
        errors++;
        $display("FAIL push_timeout actual=%0d required=<20000", t);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
      end
    end
    zone_valid = 1'b0;
    zone_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    zone_valid = 1'b0;
    zone_sof   = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || occ != 0) && t < 20000) begin
      @(posedge clock);
      t++;
    end
    #1;
    chk("drain_pending_words", exp_q.size(), 0);
    idle(GAP + 8);
  endtask

  task automatic phase_start();
    acc_cnt   = 0;
    acc6_n    = -1;
    ff1_n     = -1;
    rgb1_n    = -1;
    saw_stall = 1'b0;
  endtask

  int b_rgb, b_ff, b_err, mid, n;
  logic [15:0] exp_f0, exp_f1;

  initial begin
    zone_valid = 1'b0;
    zone_sof   = 1'b0;
    zone_data  = '0;
    rst        = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    rst = 1'b0;
    @(negedge clock);
    chk("idle_rgb_f", rgb_f, 1'b0);
    chk("idle_zone_ready", zone_ready, 1'b1);
    @(posedge clock);
    #1;

    // clean frame 1..96, back to back
    phase_start();
    b_rgb = n_rgb; b_ff = n_ff; b_err = n_err;
    for (int i = 1; i <= 96; i++) push_val(i == 1, 16'(i));
    drain();
    chk("p1_rgb_count", n_rgb - b_rgb, 16);
    chk("p1_frame_count", n_ff - b_ff, 1);
    chk("p1_err_count", n_err - b_err, 0);
    chk("p1_ready_dropped", saw_stall, 1'b1);
    chk("p1_frame_f_latency", ff1_n - acc6_n, 2);
    chk("p1_rgb_f_latency", rgb1_n - acc6_n, 3);
    chk("p1_first_word", rgb1_data, 96'h0006_0005_0004_0003_0002_0001);

    // SOF reasserted at value 9
    phase_start();
    b_rgb = n_rgb; b_ff = n_ff; b_err = n_err;
    for (int i = 1; i <= 8; i++) push_val(i == 1, 16'(i));
    for (int i = 9; i <= 104; i++) push_val(i == 9, 16'(i));
    drain();
    chk("p2_rgb_count", n_rgb - b_rgb, 17);
    chk("p2_frame_count", n_ff - b_ff, 2);
    chk("p2_err_count", n_err - b_err, 1);

    // 100 values after one SOF
    phase_start();
    b_rgb = n_rgb; b_ff = n_ff; b_err = n_err;
    for (int i = 1; i <= 100; i++) push_val(i == 1, 16'(16'h0100 + i));
    drain();
    chk("p3_rgb_count", n_rgb - b_rgb, 16);
    chk("p3_frame_count", n_ff - b_ff, 1);
    chk("p3_err_count", n_err - b_err, 1);

    // clamp behaviour
    phase_start();
    push_val(1'b1, 16'hFFFF);
    push_val(1'b0, 16'h1000);
    for (int i = 3; i <= 96; i++) push_val(1'b0, 16'(i));
    drain();
`ifdef LEVEL_CLAMP_EN
    exp_f0 = 16'h0FFF; exp_f1 = 16'h0FFF;
`else
    exp_f0 = 16'hFFFF; exp_f1 = 16'h1000;
`endif
    chk("clamp_field0", rgb1_data[15:0], exp_f0);
    chk("clamp_field1", rgb1_data[31:16], exp_f1);

    // random frames with idle gaps, early SOFs and overruns
    for (int f = 0; f < 5; f++) begin
      n   = ZPF + (($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : 0);
      mid = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, ZPF - 1)) : 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        push_val((i == 0) || (i == mid), 16'($urandom));
      end
    end
    drain();

    // reset during GAP with three words queued
    phase_start();
    b_rgb = n_rgb; b_err = n_err;
    for (int i = 1; i <= 24; i++) push_val(i == 1, 16'(16'h0200 + i));
    idle(12);
    chk("p6_queued_words", exp_q.size(), 3);
    chk("p6_one_word_sent", n_rgb - b_rgb, 1);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    idle(200);
    chk("p6_no_rgb_after_reset", n_rgb - b_rgb, 1);
    for (int i = 1; i <= 12; i++) push_val(1'b0, 16'(i));
    idle(10);
    chk("p6_silent_drop", n_err - b_err, 0);
    for (int i = 1; i <= 96; i++) push_val(i == 1, 16'(16'h0300 + i));
    drain();
    chk("p6_new_frame_words", n_rgb - b_rgb, 17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
